fetch_unit: RTL and testbench

- Producer side of the instruction fetch queue. Generates sequential PCs and issues in-order read requests to instruction memory.
- Buffers responses in a small skid buffer and pushes {word address, instr[31:2]} into the queue whenever the queue is not full.
- Handles pipeline redirects: flushes the queue, restarts at the new PC and discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch producer.
// Issues sequential word-aligned read requests to instruction memory. Responses
// land in a small skid buffer, which drains into the fetch queue as
// {word address, instr[31:2]}. A redirect flushes the queue and restarts fetch
// at a new PC. Responses to requests issued before the redirect are counted
// off and dropped.
// Ports:
//   clock, reset                       clock; synchronous active-high reset
//   haltReq                            hold off new requests
//   redirect, redirectPC               one-cycle restart pulse and target PC
//   imemReq/imemAddr/imemReady         request channel
//   imemRespValid/imemRespData         in-order response channel
//   queueFull, queuePush               queue flow control and push strobe
//   queueInstr, queueAddr              pushed payload
//   flushQueue                         queue flush (combinational with redirect)
//   illegalFetch                       pushed instruction has instr[1:0] != 2'b11
module fetch_unit #(
  parameter int              XLEN            = 32,
  parameter longint unsigned RESET_PC        = 0,
  parameter int              MAX_OUTSTANDING = 2,
  parameter int              SKID_DEPTH      = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            haltReq,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirectPC,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemReady,
  input  logic            imemRespValid,
  input  logic [31:0]     imemRespData,
  input  logic            queueFull,
  output logic            queuePush,
  output logic [29:0]     queueInstr,
  output logic [XLEN-6:0] queueAddr,
  output logic            flushQueue,
  output logic            illegalFetch
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(SKID_DEPTH + 1);
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + SKID_DEPTH + 1);
  localparam int AW = XLEN - 5;
  localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_PC);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } entry_t;

  state_t          state;
  logic [XLEN-1:0] pc, resp_pc;
  logic [OW-1:0]   outstanding, drop_cnt;
  entry_t          skid [SKID_DEPTH];
  logic [PW-1:0]   head, tail;
  logic [SW-1:0]   skid_cnt;
  logic            credit_ok, handshake, keep;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Only issue when the skid buffer has room for every response that can
  // still arrive, so a response never finds the buffer full.
  assign credit_ok = (CW'(outstanding) + CW'(skid_cnt)) < CW'(SKID_DEPTH);

  assign imemReq      = ~reset & (state == FETCH) & ~redirect &
                        (outstanding < OW'(MAX_OUTSTANDING)) & credit_ok;
  assign imemAddr     = pc;
  assign handshake    = imemReq & imemReady;
  assign queuePush    = ~reset & (skid_cnt != '0) & ~queueFull & ~redirect;
  assign queueInstr   = skid[head].data[31:2];
  assign queueAddr    = skid[head].addr;
  assign illegalFetch = queuePush & (skid[head].data[1:0] != 2'b11);
  assign flushQueue   = ~reset & redirect;
  // A response is kept only when it belongs to the current fetch stream.
  assign keep         = imemRespValid & ~redirect & (drop_cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RST_PC;
      resp_pc     <= RST_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
      skid_cnt    <= '0;
    end else begin
      case (state)
        IDLE:    state <= FETCH;
        FETCH:   if (haltReq)  state <= HALTED;
        HALTED:  if (!haltReq) state <= FETCH;
        default: state <= IDLE;
      endcase
      if (redirect && state != IDLE) state <= haltReq ? HALTED : FETCH;

      outstanding <= outstanding + OW'(handshake) - OW'(imemRespValid);

      if (redirect) begin
        pc       <= {redirectPC[XLEN-1:2], 2'b00};
        resp_pc  <= {redirectPC[XLEN-1:2], 2'b00};
        head     <= '0;
        tail     <= '0;
        skid_cnt <= '0;
        // Everything still in flight belongs to the old stream.
        drop_cnt <= outstanding - OW'(imemRespValid);
      end else begin
        if (handshake) pc <= pc + XLEN'(4);
        if (imemRespValid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (keep) begin
          assert (queuePush || skid_cnt != SW'(SKID_DEPTH));
          skid[tail] <= '{addr: resp_pc[XLEN-4:2], data: imemRespData};
          tail       <= next_ptr(tail);
          resp_pc    <= resp_pc + XLEN'(4);
        end
        if (queuePush) head <= next_ptr(head);
        skid_cnt <= skid_cnt + SW'(keep) - SW'(queuePush);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int          XLEN = 32;
  localparam logic [31:0] RPC  = 32'h100;
  localparam int          MAXO = 2;
  localparam int          SKID = 2;

  logic        clock = 0, reset = 1, haltReq = 0, redirect = 0;
  logic [31:0] redirectPC = '0, imemAddr, imemRespData = '0;
  logic        imemReq, imemReady = 0, imemRespValid = 0, queueFull = 0;
  logic        queuePush, flushQueue, illegalFetch;
  logic [29:0] queueInstr;
  logic [26:0] queueAddr;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .MAX_OUTSTANDING(MAXO), .SKID_DEPTH(SKID)) dut (
    .clock(clock), .reset(reset), .haltReq(haltReq), .redirect(redirect),
    .redirectPC(redirectPC), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemReady(imemReady), .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .queueFull(queueFull), .queuePush(queuePush), .queueInstr(queueInstr),
    .queueAddr(queueAddr), .flushQueue(flushQueue), .illegalFetch(illegalFetch)
  );

  always #5 clock = ~clock;

  // Reference model: in-flight requests (memory side) and expected queue pushes.
  typedef struct { logic [31:0] addr; logic [31:0] data; int epoch; } req_t;
  typedef struct { logic [26:0] addr; logic [31:0] data; } ent_t;
  req_t        mem_q[$];
  ent_t        exp_q[$];
  logic [26:0] push_log[$];
  logic [31:0] exp_pc = RPC;
  int          epoch = 0, compared = 0, mismatched = 0, illegal_cnt = 0, req_cnt = 0;
  bit          idle = 1, halted = 0, force_illegal = 0, allow_bad = 0;
  logic [29:0] last_illegal_instr = '1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gen_data();
    logic [31:0] d;
    if (force_illegal) return 32'h0000_0001;
    d = $urandom;
    if (!allow_bad || $urandom_range(3) != 0) d[1:0] = 2'b11;
    return d;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by what the coming edge commits.
  task automatic tick(input bit rst, input bit halt, input bit rdy, input bit full,
                      input bit rdir, input logic [31:0] rpc, input bit resp_en);
    bit exp_req, exp_push;
    req_t r;
    ent_t e;
    @(posedge clock); #1;
    reset = rst; haltReq = halt; imemReady = rdy; queueFull = full;
    redirect = rdir; redirectPC = rpc;
    imemRespValid = !rst && resp_en && mem_q.size() > 0;
    imemRespData  = imemRespValid ? mem_q[0].data : $urandom;
    #3;
    if (rst) begin
      chk("rst_imemReq", 64'(imemReq), 0);
      chk("rst_queuePush", 64'(queuePush), 0);
      chk("rst_flushQueue", 64'(flushQueue), 0);
      chk("rst_illegalFetch", 64'(illegalFetch), 0);
      mem_q.delete(); exp_q.delete();
      exp_pc = RPC; idle = 1; halted = 0; epoch++;
      return;
    end
    exp_req  = !idle && !halted && !rdir && mem_q.size() < MAXO &&
               (mem_q.size() + exp_q.size()) < SKID;
    exp_push = exp_q.size() > 0 && !full && !rdir;
    chk("imemReq", 64'(imemReq), 64'(exp_req));
    if (imemReq) begin
      chk("imemAddr", 64'(imemAddr), 64'(exp_pc));
      req_cnt++;
    end
    if (idle) chk("idle_imemAddr", 64'(imemAddr), 64'(RPC));
    chk("flushQueue", 64'(flushQueue), 64'(rdir));
    chk("queuePush", 64'(queuePush), 64'(exp_push));
    if (queuePush && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("queueAddr", 64'(queueAddr), 64'(e.addr));
      chk("queueInstr", 64'(queueInstr), 64'(e.data[31:2]));
      chk("illegalFetch", 64'(illegalFetch), 64'(e.data[1:0] != 2'b11));
      push_log.push_back(queueAddr);
      if (illegalFetch) begin
        illegal_cnt++;
        last_illegal_instr = queueInstr;
      end
    end else begin
      chk("illegal_idle", 64'(illegalFetch), 0);
    end
    if (imemRespValid) begin
      r = mem_q.pop_front();
      if (r.epoch == epoch && !rdir) exp_q.push_back('{r.addr[28:2], r.data});
    end
    if (imemReq && rdy) begin
      mem_q.push_back('{exp_pc, gen_data(), epoch});
      exp_pc += 32'd4;
    end
    if (rdir) begin
      exp_q.delete();
      epoch++;
      exp_pc = rpc & ~32'd3;
    end
    halted = !idle && halt;
    idle   = 0;
  endtask

  initial begin
    logic [26:0] last;
    bit h;
    // Reset, then free-running fetch with a 1-cycle memory.
    tick(1, 0, 1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0, 0, 0);
    push_log.delete();
    repeat (12) tick(0, 0, 1, 0, 0, 0, 1);
    chk("steady_push_cnt", 64'(push_log.size() >= 3), 1);
    if (push_log.size() >= 3) begin
      chk("first_push", 64'(push_log[0]), 64'h40);
      chk("second_push", 64'(push_log[1]), 64'h41);
      chk("third_push", 64'(push_log[2]), 64'h42);
    end

    // Queue full for 10 cycles; pushes resume sequentially afterwards.
    last = push_log[$];
    push_log.delete();
    repeat (10) tick(0, 0, 1, 1, 0, 0, 1);
    chk("full_no_push", 64'(push_log.size()), 0);
    repeat (8) tick(0, 0, 1, 0, 0, 0, 1);
    chk("resume_cnt", 64'(push_log.size() > 0), 1);
    if (push_log.size() > 0) chk("resume_addr", 64'(push_log[0]), 64'(last + 27'd1));

    // Two requests outstanding at 0x200/0x204, then redirect to 0x803.
    tick(0, 0, 1, 0, 1, 32'h200, 0);
    repeat (3) tick(0, 0, 1, 0, 0, 0, 0);
    chk("two_outstanding", 64'(mem_q.size()), 2);
    push_log.delete();
    tick(0, 0, 1, 0, 1, 32'h803, 0);
    repeat (8) tick(0, 0, 1, 0, 0, 0, 1);
    chk("redir_push_cnt", 64'(push_log.size() > 0), 1);
    if (push_log.size() > 0) chk("redir_first_push", 64'(push_log[0]), 64'h200);

    // Redirect coincident with a response.
    repeat (2) tick(0, 0, 1, 0, 0, 0, 0);
    push_log.delete();
    tick(0, 0, 1, 0, 1, 32'h400, 1);
    chk("redir_resp_no_push", 64'(push_log.size()), 0);
    repeat (8) tick(0, 0, 1, 0, 0, 0, 1);
    if (push_log.size() > 0) chk("redir2_first_push", 64'(push_log[0]), 64'h100);
    else chk("redir2_push_cnt", 0, 1);

    // Drain while halted, then one illegal instruction.
    repeat (6) tick(0, 1, 0, 0, 0, 0, 1);
    illegal_cnt = 0;
    force_illegal = 1;
    tick(0, 0, 1, 0, 0, 0, 1);
    tick(0, 0, 1, 0, 0, 0, 0);
    force_illegal = 0;
    repeat (4) tick(0, 0, 0, 0, 0, 0, 1);
    chk("illegal_cnt", 64'(illegal_cnt), 1);
    chk("illegal_instr", 64'(last_illegal_instr), 0);

    // Halt with one request outstanding.
    repeat (4) tick(0, 1, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("halt_setup_outstanding", 64'(mem_q.size()), 1);
    push_log.delete();
    tick(0, 1, 0, 0, 0, 0, 0);
    req_cnt = 0;
    repeat (5) tick(0, 1, 1, 0, 0, 0, 1);
    chk("halt_no_req", 64'(req_cnt), 0);
    chk("halt_push", 64'(push_log.size()), 1);
    repeat (6) tick(0, 0, 1, 0, 0, 0, 1);
    chk("resume_req", 64'(req_cnt > 0), 1);

    // Randomized traffic, including illegal encodings and occasional reset.
    allow_bad = 1;
    h = 0;
    repeat (1500) begin
      if ($urandom_range(19) == 0) h = ~h;
      if ($urandom_range(499) == 0) begin
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
      end else begin
        tick(0, h, $urandom_range(9) < 7, $urandom_range(9) < 3,
             !idle && $urandom_range(29) == 0, $urandom, $urandom_range(9) < 6);
      end
    end
    repeat (40) tick(0, 1, 0, 0, 0, 0, 1);
    chk("drain_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
